fifo_reader: RTL and testbench
==============================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 128, width of FIFO read data and output stream data.
REQ-002 SHALL have parameter CNT_W, default 32, width of the popped-word counter.
REQ-003 SHALL have ports: clk  in  1  sole clock, all logic on posedge.
REQ-004 SHALL have ports: rstn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: i_en  in  1  run enable; deassertion requests graceful drain.
REQ-006 SHALL have ports: o_rden  out  1  FIFO read strobe, one pop per asserted cycle.
REQ-007 SHALL have ports: i_rddata  in  DATA_W  FIFO read data, valid one cycle after o_rden.
REQ-008 SHALL have ports: i_empty  in  1  FIFO empty flag.
REQ-009 SHALL have ports: i_alm_empty  in  1  FIFO almost-empty flag (at most one entry).
REQ-010 SHALL have ports: o_valid  out  1  output stream data valid.
REQ-011 SHALL have ports: i_ready  in  1  downstream accept; a transfer occurs when o_valid and i_ready are both high.
REQ-012 SHALL have ports: o_data  out  DATA_W  output stream data.
REQ-013 SHALL have ports: o_busy  out  1  high in RUN or DRAIN state.
REQ-014 SHALL have ports: o_pop_cnt  out  CNT_W  total FIFO pops since reset.

Function
REQ-015 SHALL implement FSM IDLE, RUN, DRAIN. IDLE->RUN when i_en=1. RUN->DRAIN when i_en=0. DRAIN->IDLE when no read is in flight and the buffer is empty. DRAIN->RUN when i_en=1.
REQ-016 SHALL hold read data in a 2-entry output buffer; o_data is the oldest entry and o_valid = (buf_cnt != 0).
REQ-017 SHALL have fixed FIFO read latency of 1: data from o_rden at cycle t is written into the buffer at the end of cycle t+1.
REQ-018 SHALL assert o_rden only in RUN, with i_empty=0, and with buf_cnt + inflight - (o_valid & i_ready) < 2.
REQ-019 SHALL, when i_alm_empty=1, not assert o_rden in a cycle directly following an o_rden cycle (no back-to-back pops near empty).
REQ-020 SHALL sustain one transfer per cycle when the FIFO is not almost-empty and i_ready is held high.
REQ-021 SHALL hold o_data and o_valid stable while o_valid=1 and i_ready=0; the buffer never overflows or drops data.
REQ-022 SHALL, on simultaneous buffer write and stream transfer, keep buf_cnt unchanged and preserve order.
REQ-023 SHALL increment o_pop_cnt on every o_rden and wrap modulo 2^CNT_W.
REQ-024 SHALL, in DRAIN, never assert o_rden, and SHALL still deliver in-flight and buffered words.
REQ-025 SHALL treat o_rden as a pure function of registered state and current inputs, with no combinational path from i_rddata.

Reset
REQ-026 SHALL, when rstn=0, asynchronously force state=IDLE, buf_cnt=0, inflight=0, o_rden=0, o_valid=0, o_data=0, o_busy=0, o_pop_cnt=0.
REQ-027 SHALL, on reset mid-operation, discard buffered and in-flight data, and SHALL ignore FIFO data returning in the first cycle after reset release.

Structure
REQ-028 SHALL place the FSM state enum (IDLE/RUN/DRAIN) and default DATA_W/CNT_W constants in shared package fifo_pkg.
REQ-029 SHALL implement the 2-entry buffer as sub-module fifo_rd_skid (write, pop, count, head data).

Verification
REQ-030 SHALL be verified by: reset, i_en=1, FIFO preloaded with 8 words 0x1..0x8, i_ready=1 -> o_data 0x1..0x8 in order, o_pop_cnt=8, 8 transfers within 12 cycles.
REQ-031 SHALL be verified by: 4 words preloaded, i_ready=0 for 10 cycles, then i_ready=1 -> exactly 2 pops while stalled, o_data=0x1 held stable, all 4 words later delivered in order.
REQ-032 SHALL be verified by: 1 word preloaded with i_alm_empty=1 -> single o_rden, no second pop, o_valid for one transfer, then idle with o_valid=0.
REQ-033 SHALL be verified by: i_en dropped mid-stream with 2 words buffered -> no further o_rden, both words delivered, then o_busy=0 and state IDLE.
REQ-034 SHALL be verified by: rstn pulsed low while o_valid=1 and a read is in flight -> all outputs zero immediately, no stale word appears after release.
REQ-035 SHALL be verified by: o_pop_cnt forced near wrap (CNT_W=4 build), 20 pops -> o_pop_cnt=4.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FSM state type and default widths for the FIFO reader
package fifo_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - two-entry in-order output buffer for FIFO read data
module fifo_rd_skid #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              pop_i,
  output logic [1:0]        cnt_o,
  output logic [DATA_W-1:0] head_o
);

  logic [DATA_W-1:0] ent0_q, ent0_d;
  logic [DATA_W-1:0] ent1_q, ent1_d;
  logic [1:0]        cnt_q, cnt_d;

  // ent0 is always the oldest word; ent1 only holds data when two are queued
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({wr_en_i, pop_i})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          ent0_d = wr_data_i;
          cnt_d  = 2'd1;
        end else if (cnt_q == 2'd1) begin
          ent1_d = wr_data_i;
          cnt_d  = 2'd2;
        end
      end
      2'b01: begin
        if (cnt_q != 2'd0) begin
          ent0_d = ent1_q;
          cnt_d  = cnt_q - 2'd1;
        end
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          ent0_d = ent1_q;
          ent1_d = wr_data_i;
        end else if (cnt_q == 2'd1) begin
          ent0_d = wr_data_i;
        end else begin
          ent0_d = wr_data_i;
          cnt_d  = 2'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign head_o = ent0_q;

endmodule

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - pops a latency-1 FIFO into a ready/valid stream with graceful drain
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_en,
  output logic              o_rden,
  input  logic [DATA_W-1:0] i_rddata,
  input  logic              i_empty,
  input  logic              i_alm_empty,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_pop_cnt
);

  rd_state_e        state_q, state_d;
  logic             inflight_q;
  logic [CNT_W-1:0] pop_cnt_q;
  logic [1:0]       buf_cnt;
  logic             xfer;
  logic [2:0]       occ_next;

  assign o_valid = (buf_cnt != 2'd0);
  assign xfer    = o_valid & i_ready;

  // Occupancy after this edge; a new pop only lands one cycle later, so this must leave a slot
  assign occ_next = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, xfer};

  assign o_rden = (state_q == ST_RUN) && i_en && !i_empty && (occ_next < 3'd2) &&
                  !(i_alm_empty && inflight_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_en) state_d = ST_RUN;
      ST_RUN:   if (!i_en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (i_en) state_d = ST_RUN;
        else if (!inflight_q && (buf_cnt == 2'd0)) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
      pop_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= o_rden;
      pop_cnt_q  <= pop_cnt_q + {{(CNT_W-1){1'b0}}, o_rden};
    end
  end

  fifo_rd_skid #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en_i  (inflight_q),
    .wr_data_i(i_rddata),
    .pop_i    (xfer),
    .cnt_o    (buf_cnt),
    .head_o   (o_data)
  );

  assign o_busy    = (state_q != ST_IDLE);
  assign o_pop_cnt = pop_cnt_q;

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - scoreboard bench for fifo_reader with a queue-based FIFO model
module tb_fifo_reader;

  localparam int DATA_W = 128;
  localparam int CNT_W  = 4;

  typedef logic [127:0] word_t;

  logic              clk;
  logic              rstn;
  logic              i_en;
  logic              o_rden;
  logic [DATA_W-1:0] i_rddata;
  logic              i_empty;
  logic              i_alm_empty;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_busy;
  logic [CNT_W-1:0]  o_pop_cnt;

  fifo_reader #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_en       (i_en),
    .o_rden     (o_rden),
    .i_rddata   (i_rddata),
    .i_empty    (i_empty),
    .i_alm_empty(i_alm_empty),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_busy     (o_busy),
    .o_pop_cnt  (o_pop_cnt)
  );

  word_t fifo_q[$];
  word_t exp_q[$];
  int    vectors;
  int    miscompares;
  int    model_pops;
  int    delivered;
  int    pops_seen;
  logic  rden_seen;
  logic  last_rden;
  logic  stall_prev;
  word_t stall_data;

  always #5 clk = ~clk;

  task automatic check(input string name, input word_t got, input word_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic word_t rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void update_flags();
    i_empty     = (fifo_q.size() == 0);
    i_alm_empty = (fifo_q.size() <= 1);
  endfunction

  task automatic push_word(input word_t w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    update_flags();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // FIFO model: a pop seen before the edge returns its word one cycle later
  always @(posedge clk) begin
    #1;
    if (rden_seen && fifo_q.size() > 0) begin
      i_rddata = fifo_q.pop_front();
      model_pops++;
    end else begin
      i_rddata = rand_word();
    end
    update_flags();
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", word_t'(o_data), word_t'(0) - 1);
        end else begin
          check("stream_data", word_t'(o_data), exp_q.pop_front());
          delivered++;
        end
      end
      if (stall_prev) begin
        check("stall_valid", word_t'(o_valid), word_t'(1));
        check("stall_data", word_t'(o_data), stall_data);
      end
      stall_prev = o_valid && !i_ready;
      stall_data = word_t'(o_data);
      if (o_rden) begin
        pops_seen++;
        check("rden_nonempty", word_t'(fifo_q.size() > 0), word_t'(1));
        check("rden_enabled", word_t'(i_en), word_t'(1));
        check("rden_b2b_alm", word_t'(last_rden && i_alm_empty), word_t'(0));
      end
      check("pop_cnt", word_t'(o_pop_cnt), word_t'(model_pops % 16));
      rden_seen = o_rden;
      last_rden = o_rden;
    end else begin
      rden_seen  = 1'b0;
      last_rden  = 1'b0;
      stall_prev = 1'b0;
    end
  end

  task automatic check_reset_outputs();
    check("rst_rden", word_t'(o_rden), word_t'(0));
    check("rst_valid", word_t'(o_valid), word_t'(0));
    check("rst_data", word_t'(o_data), word_t'(0));
    check("rst_busy", word_t'(o_busy), word_t'(0));
    check("rst_pop_cnt", word_t'(o_pop_cnt), word_t'(0));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    check_reset_outputs();
    fifo_q.delete();
    exp_q.delete();
    model_pops = 0;
    delivered  = 0;
    pops_seen  = 0;
    rden_seen  = 1'b0;
    last_rden  = 1'b0;
    stall_prev = 1'b0;
    update_flags();
    tick(2);
    rstn = 1'b1;
    tick(1);
  endtask

  task automatic wait_delivered(input int n, input int budget, input string name);
    for (int i = 0; i < budget && delivered < n; i++) tick(1);
    check(name, word_t'(delivered), word_t'(n));
  endtask

  initial begin
    clk = 1'b0;
    rstn = 1'b0;
    i_en = 1'b0;
    i_ready = 1'b0;
    i_rddata = '0;
    vectors = 0;
    miscompares = 0;
    model_pops = 0;
    delivered = 0;
    pops_seen = 0;
    rden_seen = 1'b0;
    last_rden = 1'b0;
    stall_prev = 1'b0;
    stall_data = '0;
    update_flags();
    #1;
    check_reset_outputs();
    tick(2);
    rstn = 1'b1;
    tick(1);

    // Full-rate streaming of 8 preloaded words
    for (int i = 1; i <= 8; i++) push_word(word_t'(i));
    i_ready = 1'b1;
    i_en = 1'b1;
    tick(12);
    check("burst8_delivered", word_t'(delivered), word_t'(8));
    check("burst8_pop_cnt", word_t'(o_pop_cnt), word_t'(8));
    i_en = 1'b0;
    tick(3);

    // Downstream stall: only two pops fit, head held
    do_reset();
    for (int i = 1; i <= 4; i++) push_word(word_t'(i));
    i_ready = 1'b0;
    i_en = 1'b1;
    tick(10);
    check("stall_pops", word_t'(pops_seen), word_t'(2));
    check("stall_head_valid", word_t'(o_valid), word_t'(1));
    check("stall_head_data", word_t'(o_data), word_t'(1));
    i_ready = 1'b1;
    wait_delivered(4, 20, "stall_all_delivered");

    // Single word near empty
    i_en = 1'b0;
    do_reset();
    push_word(word_t'(32'hA5));
    i_ready = 1'b1;
    i_en = 1'b1;
    tick(8);
    check("single_pops", word_t'(pops_seen), word_t'(1));
    check("single_delivered", word_t'(delivered), word_t'(1));
    check("single_valid_low", word_t'(o_valid), word_t'(0));

    // Graceful drain with two words buffered, then resume
    i_en = 1'b0;
    do_reset();
    for (int i = 1; i <= 6; i++) push_word(word_t'(16 + i));
    i_ready = 1'b0;
    i_en = 1'b1;
    tick(6);
    check("drain_pops_before", word_t'(pops_seen), word_t'(2));
    i_en = 1'b0;
    i_ready = 1'b1;
    tick(6);
    check("drain_delivered", word_t'(delivered), word_t'(2));
    check("drain_pops_after", word_t'(pops_seen), word_t'(2));
    check("drain_idle", word_t'(o_busy), word_t'(0));
    i_en = 1'b1;
    wait_delivered(6, 20, "drain_resume_delivered");

    // Reset while a word is buffered and another is in flight
    i_en = 1'b0;
    do_reset();
    for (int i = 1; i <= 6; i++) push_word(word_t'(48 + i));
    i_ready = 1'b0;
    i_en = 1'b1;
    for (int i = 0; i < 10 && !(o_valid && last_rden); i++) tick(1);
    check("midrst_setup", word_t'(o_valid && last_rden), word_t'(1));
    do_reset();
    i_ready = 1'b1;
    tick(10);
    check("midrst_no_stale", word_t'(delivered), word_t'(0));
    check("midrst_valid_low", word_t'(o_valid), word_t'(0));

    // Randomised traffic with random stalls and enable drops
    for (int c = 0; c < 400; c++) begin
      i_ready = ($urandom_range(3) != 0);
      i_en = ($urandom_range(9) != 0);
      if ($urandom_range(2) == 0) push_word(rand_word());
      tick(1);
    end
    i_en = 1'b1;
    i_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    check("random_all_delivered", word_t'(exp_q.size()), word_t'(0));

    // Pop counter wrap on the narrow counter
    i_en = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) push_word(rand_word());
    i_ready = 1'b1;
    i_en = 1'b1;
    wait_delivered(20, 60, "wrap_delivered");
    check("wrap_pop_cnt", word_t'(o_pop_cnt), word_t'(4));

    i_en = 1'b0;
    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
